trigger_combiner: RTL



---
 rtl/trigger_combiner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/trigger_combiner.sv
// Combines one-cycle trigger pulses from several sources (ANY / ALL) and emits a
// single delayed trigger pulse followed by a programmable holdoff window.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a combine event; config writes accepted here only
// DELAY    | counting down the programmed output delay
// OUT_HOLD | trigger_out high for this single cycle
// HOLDOFF  | counting down the holdoff window; events are dropped and counted
module trigger_combiner #(
  parameter int CHANNELS      = 8,
  parameter int DELAY_WIDTH   = 8,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [CHANNELS+DELAY_WIDTH+HOLDOFF_WIDTH:0]  cfg_data,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [CHANNELS-1:0]                          triggers_in,
  output logic                                         trigger_out,
  output logic                                         busy,
  output logic [COUNT_WIDTH-1:0]                       dropped_count
);

  localparam int CNT_WIDTH = (HOLDOFF_WIDTH > DELAY_WIDTH) ? HOLDOFF_WIDTH : DELAY_WIDTH;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELAY    = 2'd1,
    OUT_HOLD = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t                   state;
  logic [CHANNELS-1:0]      mask_q;
  logic                     mode_q;
  logic [DELAY_WIDTH-1:0]   delay_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [CHANNELS-1:0]      latch_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  logic [CHANNELS-1:0]      masked;
  logic [CHANNELS-1:0]      merged;
  logic                     comb_event;
  logic                     cfg_hs;

  assign cfg_ready = (state == IDLE) && !reset;
  assign cfg_hs    = cfg_valid && cfg_ready;

  // An empty mask never produces an event, in either mode.
  always_comb begin
    masked     = triggers_in & mask_q;
    merged     = latch_q | masked;
    comb_event = 1'b0;
    if (mask_q != '0) begin
      if (mode_q) comb_event = ((merged & mask_q) == mask_q);
      else        comb_event = |masked;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mask_q        <= '0;
      mode_q        <= 1'b0;
      delay_q       <= '0;
      holdoff_q     <= '0;
      latch_q       <= '0;
      cnt_q         <= '0;
      trigger_out   <= 1'b0;
      busy          <= 1'b0;
      dropped_count <= '0;
    end else begin
      trigger_out <= 1'b0;

      // ALL-mode arrivals keep accumulating even while busy; completion clears them.
      if (mode_q) latch_q <= comb_event ? '0 : merged;

      if (comb_event && (state != IDLE) && (dropped_count != '1))
        dropped_count <= dropped_count + COUNT_WIDTH'(1);

      case (state)
        IDLE: begin
          if (cfg_hs) begin
            mask_q    <= cfg_data[CHANNELS-1:0];
            mode_q    <= cfg_data[CHANNELS];
            delay_q   <= cfg_data[CHANNELS+DELAY_WIDTH:CHANNELS+1];
            holdoff_q <= cfg_data[CHANNELS+DELAY_WIDTH+HOLDOFF_WIDTH:CHANNELS+DELAY_WIDTH+1];
            latch_q   <= '0;
          end else if (comb_event) begin
            busy <= 1'b1;
            if (delay_q == '0) begin
              state       <= OUT_HOLD;
              trigger_out <= 1'b1;
            end else begin
              cnt_q <= CNT_WIDTH'(delay_q - DELAY_WIDTH'(1));
              state <= DELAY;
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state       <= OUT_HOLD;
            trigger_out <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        OUT_HOLD: begin
          if (holdoff_q == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt_q <= CNT_WIDTH'(holdoff_q - HOLDOFF_WIDTH'(1));
            state <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt_q == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
